packer_fetch_arb: RTL and testbench
===================================

Name: packer_fetch_arb

Overview:
Shares one single-cycle-latency on-chip read port among NUM_REQ packer instances. Each packer streams up to NUM_DATA words into its shift buffer.
- Per requester: holds a base address and a word budget, both loaded on that requester's start pulse.
- Each cycle: picks one eligible requester round-robin, issues a read for it, and returns the word with a per-requester valid exactly 1 clk after issue.
- Placement: between the weight/activation SRAM read port and the packer bank.

Parameters:
NUM_REQ, 4, number of packer requesters (2..8)
NUM_DATA, 32, maximum words per packer burst
DATA_WIDTH, 8, word width
ADDR_WIDTH, 12, read-port address width
CNT_W, `C_LOG_2(NUM_DATA)+1, width of a per-requester budget field (range 0..NUM_DATA)

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  asynchronous active-high reset
Sta  in  NUM_REQ  per-requester start pulse; loads that requester's context
NumPacker  in  NUM_REQ*CNT_W  per-requester word budget, sampled on Sta[i]
AddrBase  in  NUM_REQ*ADDR_WIDTH  per-requester start address, sampled on Sta[i]
ReqDat  in  NUM_REQ  level request from each packer
ValDat  out  NUM_REQ  one-hot data valid, 1 clk after the grant
Dat  out  DATA_WIDTH  returned word, shared by all requesters
RdRdy  in  1  read port can accept a read this cycle
RdEn  out  1  read strobe (combinational)
RdAddr  out  ADDR_WIDTH  read address (combinational)
RdDat  in  DATA_WIDTH  read data, valid 1 clk after RdEn
Idle  out  1  high when no budget remains anywhere and nothing is in flight

Behaviour:
- Reset (rst high, async): all Rem[i]=0, Ptr[i]=0, ValDat=0, Dat=0, round-robin pointer=0, in-flight flag=0. Combinationally during reset: RdEn=0, Idle=1.
- Per-requester context: Rem[i] (CNT_W bits, words left) and Ptr[i] (ADDR_WIDTH bits, next address).
- Sta[i]: Rem[i]<=NumPacker[i], Ptr[i]<=AddrBase[i].
  - Sta[i] overrides a same-cycle grant to i; i is not granted that cycle.
  - NumPacker=0 leaves i ineligible.
  - Sta[i] arriving mid-burst discards the old context; a word already in flight for i is still delivered.
- Eligible[i] = ReqDat[i] && Rem[i]!=0 && !Sta[i].
- Grant: when RdRdy && |Eligible, grant the first eligible index at or after the RR pointer, modulo NUM_REQ.
  - Same cycle: RdEn=1, RdAddr=Ptr[g].
  - On the clock edge: Ptr[g]+=1 (wraps mod 2^ADDR_WIDTH), Rem[g]-=1, RR pointer<=g+1 mod NUM_REQ.
  - RdRdy=0: no grant, no state change except Sta loads.
- Return path:
  - Registered one-hot of g becomes ValDat on the cycle after the grant.
  - Dat is RdDat, passed combinationally from the read port (RdDat is itself registered), and equals the word for that ValDat.
  - Dat holds its last value when ValDat=0.
- Throughput: one word per cycle aggregate. Back-to-back grants to the same requester are allowed when it is the only eligible one.
- Over-fetch guard: the Rem check stops issue at the budget even if a packer holds ReqDat high one cycle late after its last ValDat.
- Idle = (all Rem==0) && !in-flight.
- Simultaneous Sta on several requesters: each loads independently.
- ReqDat deasserting mid-burst: the requester drops out of arbitration and keeps Rem/Ptr; it resumes at Ptr on re-request.

Optional Feature:
Macro FETCH_ARB_LOCK_EN.
- Defined: burst lock.
  - Once requester g is granted, only g is eligible until Rem[g]==0, ReqDat[g] drops, or Sta[g] fires.
  - Then the RR pointer<=g+1 and arbitration proceeds normally.
  - Result: each burst's RdAddr sequence is contiguous for SRAM bank-conflict avoidance.
- Undefined: per-word round-robin as described above. Lock register and logic are absent.

Test Plan:
1. Single requester: Sta[0], NumPacker=4, AddrBase=0x010, ReqDat[0] held -> RdAddr 0x010..0x013 on 4 consecutive cycles; ValDat[0] on the 4 following cycles carrying RdDat; Idle returns to 1.
2. Two requesters, budgets 3 and 3, bases 0x000/0x100, both requesting, RdRdy=1 -> RdAddr 0x000,0x100,0x001,0x101,0x002,0x102. With FETCH_ARB_LOCK_EN: 0x000,0x001,0x002,0x100,0x101,0x102.
3. RdRdy pattern 1,0,0,1,1 with requester 2, budget 3 -> no RdEn while RdRdy=0; exactly 3 ValDat[2] pulses, each 1 clk after the corresponding RdEn.
4. ReqDat[1] held high 2 clk past its budget of 2 -> exactly 2 grants; no RdEn for 1 afterwards; Rem[1]=0.
5. Sta[3] reissued mid-burst with new base 0x200, budget 2 -> the pending word still arrives on ValDat[3]; the next RdAddr for 3 is 0x200, then 0x201; then it stops.
6. rst asserted mid-burst -> ValDat=0 and RdEn=0 immediately; after release, Idle=1 and no grants until a new Sta.

Source files
------------

// File: rtl/packer_fetch_arb.sv
// packer_fetch_arb: round-robin sharing of one 1-cycle-latency read port among NUM_REQ packers.
// Define FETCH_ARB_LOCK_EN to hold each grant on one requester until its burst ends (contiguous RdAddr).
module packer_fetch_arb #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_DATA   = 32,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_W      = $clog2(NUM_DATA) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            Sta,
    input  logic [NUM_REQ*CNT_W-1:0]      NumPacker,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] AddrBase,
    input  logic [NUM_REQ-1:0]            ReqDat,
    output logic [NUM_REQ-1:0]            ValDat,
    output logic [DATA_WIDTH-1:0]         Dat,
    input  logic                          RdRdy,
    output logic                          RdEn,
    output logic [ADDR_WIDTH-1:0]         RdAddr,
    input  logic [DATA_WIDTH-1:0]         RdDat,
    output logic                          Idle
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [CNT_W-1:0]      r_rem [NUM_REQ];
    logic [ADDR_WIDTH-1:0] r_ptr [NUM_REQ];
    logic [IDX_W-1:0]      r_rr;
    logic [NUM_REQ-1:0]    r_val;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_dat_last;

    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_arb_elig;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic                  w_grant;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic [IDX_W-1:0]      w_rr_next;
    logic                  w_all_empty;

    // A start pulse on a requester blocks its grant in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = ReqDat[i] && (r_rem[i] != '0) && !Sta[i];
        end
    end

`ifdef FETCH_ARB_LOCK_EN
    logic             r_lock_vld;
    logic [IDX_W-1:0] r_lock_id;

    always_comb begin
        w_arb_elig = w_elig;
        if (r_lock_vld && w_elig[r_lock_id]) begin
            w_arb_elig            = '0;
            w_arb_elig[r_lock_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
        end else if (w_grant) begin
            r_lock_vld <= 1'b1;
            r_lock_id  <= w_gnt_idx;
        end else if (!w_elig[r_lock_id]) begin
            r_lock_vld <= 1'b0;
        end
    end
`else
    assign w_arb_elig = w_elig;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        int idx;
        w_grant   = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        idx       = 0;
        if (!rst && RdRdy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(r_rr) + k) % NUM_REQ;
                if (!w_grant && w_arb_elig[idx]) begin
                    w_grant   = 1'b1;
                    w_gnt_idx = IDX_W'(idx);
                end
            end
        end
        if (w_grant) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
        end
    end

    assign w_rr_next = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_all_empty = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_rem[i] != '0) begin
                w_all_empty = 1'b0;
            end
        end
    end

    // NOTE: the context arrays are reset because eligibility and Idle read them straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rem[i] <= '0;
                r_ptr[i] <= '0;
            end
            r_rr       <= '0;
            r_val      <= '0;
            r_inflight <= 1'b0;
            r_dat_last <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (Sta[i]) begin
                    r_rem[i] <= NumPacker[i*CNT_W +: CNT_W];
                    r_ptr[i] <= AddrBase[i*ADDR_WIDTH +: ADDR_WIDTH];
                end else if (w_gnt_oh[i]) begin
                    r_rem[i] <= r_rem[i] - 1'b1;
                    r_ptr[i] <= r_ptr[i] + 1'b1;
                end
            end
            if (w_grant) begin
                r_rr <= w_rr_next;
            end
            r_val      <= w_gnt_oh;
            r_inflight <= w_grant;
            r_dat_last <= Dat;
        end
    end

    assign RdEn   = w_grant;
    assign RdAddr = w_grant ? r_ptr[w_gnt_idx] : '0;
    assign ValDat = r_val;
    // The read port registers its data, so the word can be forwarded without another flop.
    assign Dat    = (|r_val) ? RdDat : r_dat_last;
    assign Idle   = w_all_empty && !r_inflight;

endmodule

// File: tb/tb_packer_fetch_arb.sv
// tb_packer_fetch_arb: table-driven vectors plus hand sequences; returned words checked via a scoreboard queue.
module tb_packer_fetch_arb;
    localparam int NUM_REQ    = 4;
    localparam int NUM_DATA   = 32;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 12;
    localparam int CNT_W      = $clog2(NUM_DATA) + 1;

    typedef struct {
        logic [NUM_REQ-1:0]    sta;
        logic [NUM_REQ-1:0]    req;
        logic                  rdy;
        logic                  exp_en;
        int                    exp_gnt;
        logic [ADDR_WIDTH-1:0] exp_addr;
        int                    exp_idle;
        int                    num  [NUM_REQ];
        int                    base [NUM_REQ];
    } vec_t;

    typedef struct {
        int                    idx;
        logic [DATA_WIDTH-1:0] dat;
    } sb_t;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            Sta;
    logic [NUM_REQ*CNT_W-1:0]      NumPacker;
    logic [NUM_REQ*ADDR_WIDTH-1:0] AddrBase;
    logic [NUM_REQ-1:0]            ReqDat;
    logic [NUM_REQ-1:0]            ValDat;
    logic [DATA_WIDTH-1:0]         Dat;
    logic                          RdRdy;
    logic                          RdEn;
    logic [ADDR_WIDTH-1:0]         RdAddr;
    logic [DATA_WIDTH-1:0]         RdDat;
    logic                          Idle;

    int n_checks = 0;
    int n_errors = 0;
    sb_t  sb [$];
    vec_t tbl [$];
    int   cur_num  [NUM_REQ];
    int   cur_base [NUM_REQ];
    logic [DATA_WIDTH-1:0] last_dat = '0;

    packer_fetch_arb #(
        .NUM_REQ(NUM_REQ), .NUM_DATA(NUM_DATA), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .Sta(Sta), .NumPacker(NumPacker), .AddrBase(AddrBase),
        .ReqDat(ReqDat), .ValDat(ValDat), .Dat(Dat), .RdRdy(RdRdy), .RdEn(RdEn),
        .RdAddr(RdAddr), .RdDat(RdDat), .Idle(Idle)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] mem_f(input logic [ADDR_WIDTH-1:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
    endfunction

    // Read port model: registered data, junk when no read so Dat hold is observable.
    always @(posedge clk) begin
        if (RdEn === 1'b1) RdDat <= mem_f(RdAddr);
        else               RdDat <= DATA_WIDTH'($urandom);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ctx(input int i, input int n, input int base);
        NumPacker[i*CNT_W +: CNT_W]           = CNT_W'(n);
        AddrBase[i*ADDR_WIDTH +: ADDR_WIDTH]  = ADDR_WIDTH'(base);
    endtask

    // Drives one cycle, checks outputs at the falling edge, leaves time at posedge+1.
    task automatic step(input logic [NUM_REQ-1:0] sta, input logic [NUM_REQ-1:0] req,
                        input logic rdy, input logic exp_en, input int exp_gnt,
                        input logic [ADDR_WIDTH-1:0] exp_addr, input int exp_idle, input string name);
        sb_t e;
        logic [NUM_REQ-1:0] oh;
        Sta = sta; ReqDat = req; RdRdy = rdy;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            check({name, "/valdat"}, 64'(ValDat), 64'(oh));
            check({name, "/dat"}, 64'(Dat), 64'(e.dat));
            last_dat = e.dat;
        end else begin
            check({name, "/valdat_idle"}, 64'(ValDat), 64'(0));
            check({name, "/dat_hold"}, 64'(Dat), 64'(last_dat));
        end
        check({name, "/rden"}, 64'(RdEn), 64'(exp_en));
        if (exp_en) begin
            check({name, "/rdaddr"}, 64'(RdAddr), 64'(exp_addr));
            e.idx = exp_gnt;
            e.dat = mem_f(exp_addr);
            sb.push_back(e);
        end
        if (exp_idle >= 0) check({name, "/idle"}, 64'(Idle), 64'(exp_idle));
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [NUM_REQ-1:0] sta, input logic [NUM_REQ-1:0] req,
                                input logic rdy, input logic en, input int gnt,
                                input int addr, input int idle);
        vec_t v;
        v.sta = sta; v.req = req; v.rdy = rdy; v.exp_en = en; v.exp_gnt = gnt;
        v.exp_addr = ADDR_WIDTH'(addr); v.exp_idle = idle;
        v.num = cur_num; v.base = cur_base;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; Sta = '0; ReqDat = '1; RdRdy = 1'b1; NumPacker = '0; AddrBase = '0;
        cur_num = '{0, 0, 0, 0};
        cur_base = '{0, 0, 0, 0};

        // Two requesters, budgets 3/3, simultaneous start
        cur_num = '{3, 3, 0, 0}; cur_base = '{'h000, 'h100, 0, 0};
        add(4'b0011, 4'b0011, 1, 0, 0, 0, 1);
`ifdef FETCH_ARB_LOCK_EN
        add(0, 4'b0011, 1, 1, 0, 'h000, 0); add(0, 4'b0011, 1, 1, 0, 'h001, -1);
        add(0, 4'b0011, 1, 1, 0, 'h002, -1); add(0, 4'b0011, 1, 1, 1, 'h100, -1);
        add(0, 4'b0011, 1, 1, 1, 'h101, -1); add(0, 4'b0011, 1, 1, 1, 'h102, -1);
`else
        add(0, 4'b0011, 1, 1, 0, 'h000, 0); add(0, 4'b0011, 1, 1, 1, 'h100, -1);
        add(0, 4'b0011, 1, 1, 0, 'h001, -1); add(0, 4'b0011, 1, 1, 1, 'h101, -1);
        add(0, 4'b0011, 1, 1, 0, 'h002, -1); add(0, 4'b0011, 1, 1, 1, 'h102, -1);
`endif
        add(0, 4'b0011, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 1);

        // Single requester 0, budget 4 at 0x010, request held past the budget
        cur_num = '{4, 0, 0, 0}; cur_base = '{'h010, 0, 0, 0};
        add(4'b0001, 4'b0001, 1, 0, 0, 0, 1);
        add(0, 4'b0001, 1, 1, 0, 'h010, 0); add(0, 4'b0001, 1, 1, 0, 'h011, -1);
        add(0, 4'b0001, 1, 1, 0, 'h012, -1); add(0, 4'b0001, 1, 1, 0, 'h013, -1);
        add(0, 4'b0001, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 1);

        // Requester 2, budget 3, RdRdy pattern 1,0,0,1,1
        cur_num = '{0, 0, 3, 0}; cur_base = '{0, 0, 'h030, 0};
        add(4'b0100, 4'b0100, 1, 0, 0, 0, -1);
        add(0, 4'b0100, 1, 1, 2, 'h030, -1); add(0, 4'b0100, 0, 0, 0, 0, 0);
        add(0, 4'b0100, 0, 0, 0, 0, -1);     add(0, 4'b0100, 1, 1, 2, 'h031, -1);
        add(0, 4'b0100, 1, 1, 2, 'h032, -1); add(0, 4'b0100, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 1);

        // Reset state, with requests and RdRdy high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/valdat", 64'(ValDat), 64'(0));
        check("reset/rden", 64'(RdEn), 64'(0));
        check("reset/idle", 64'(Idle), 64'(1));
        check("reset/dat", 64'(Dat), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < tbl.size(); v++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tbl[v].sta[i]) set_ctx(i, tbl[v].num[i], tbl[v].base[i]);
            end
            step(tbl[v].sta, tbl[v].req, tbl[v].rdy, tbl[v].exp_en, tbl[v].exp_gnt,
                 tbl[v].exp_addr, tbl[v].exp_idle, $sformatf("vec%0d", v));
        end

        // Over-fetch guard: requester 1 holds ReqDat 2 cycles past budget 2
        set_ctx(1, 2, 'h0F0);
        step(4'b0010, 4'b0010, 1, 0, 0, 0, -1, "ovf/sta");
        step(0, 4'b0010, 1, 1, 1, 'h0F0, -1, "ovf/g0");
        step(0, 4'b0010, 1, 1, 1, 'h0F1, -1, "ovf/g1");
        step(0, 4'b0010, 1, 0, 0, 0, 0, "ovf/late0");
        step(0, 4'b0010, 1, 0, 0, 0, 1, "ovf/late1");

        // Restart requester 3 mid-burst; the in-flight word still returns
        set_ctx(3, 4, 'h050);
        step(4'b1000, 4'b1000, 1, 0, 0, 0, -1, "rsta/sta0");
        step(0, 4'b1000, 1, 1, 3, 'h050, -1, "rsta/g0");
        step(0, 4'b1000, 1, 1, 3, 'h051, -1, "rsta/g1");
        set_ctx(3, 2, 'h200);
        step(4'b1000, 4'b1000, 1, 0, 0, 0, -1, "rsta/sta1");
        step(0, 4'b1000, 1, 1, 3, 'h200, -1, "rsta/g2");
        step(0, 4'b1000, 1, 1, 3, 'h201, -1, "rsta/g3");
        step(0, 4'b1000, 1, 0, 0, 0, 0, "rsta/stop");
        step(0, 4'b1000, 1, 0, 0, 0, 1, "rsta/idle");

        // Reset mid-burst
        set_ctx(0, 5, 'h060);
        step(4'b0001, 4'b0001, 1, 0, 0, 0, -1, "mrst/sta");
        step(0, 4'b0001, 1, 1, 0, 'h060, -1, "mrst/g0");
        step(0, 4'b0001, 1, 1, 0, 'h061, -1, "mrst/g1");
        rst = 1'b1;
        #1;
        check("mrst/valdat", 64'(ValDat), 64'(0));
        check("mrst/rden", 64'(RdEn), 64'(0));
        check("mrst/idle", 64'(Idle), 64'(1));
        sb.delete();
        last_dat = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 4'b0001, 1, 0, 0, 0, 1, "mrst/post0");
        step(0, 4'b0001, 1, 0, 0, 0, 1, "mrst/post1");
        set_ctx(0, 1, 'h070);
        step(4'b0001, 4'b0001, 1, 0, 0, 0, -1, "mrst/sta2");
        step(0, 4'b0001, 1, 1, 0, 'h070, 0, "mrst/g2");
        step(0, 4'b0001, 1, 0, 0, 0, 0, "mrst/drain");
        step(0, 4'b0000, 1, 0, 0, 0, 1, "mrst/done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
